// File: rtl/hex7seg_scan_driver.sv
// Multiplexed hexadecimal 7-segment driver: refresh prescaler, digit scan,
// frame-synchronous double buffering, leading-zero blanking and a dark guard slot.
module hex7seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      blank_lz,
    input  logic                      enable,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_start
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_UNLIT = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_UNLIT  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic [PRE_W-1:0]          prescaler_reg, prescaler_next;
    logic [IDX_W-1:0]          index_reg, index_next;
    logic [4*NUM_DIGITS-1:0]   pending_value_reg, active_value_reg;
    logic [NUM_DIGITS-1:0]     pending_dp_reg, active_dp_reg;
    logic                      wrapped_reg;
    logic [6:0]                seg_reg, seg_next;
    logic                      dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]     an_reg, an_next;
    logic                      frame_start_reg;

    logic                      slot_end, frame_wrap, in_guard, blank;
    logic [NUM_DIGITS-1:0]     digit_sel;
    logic [NUM_DIGITS:0]       upper_zero;
    logic [3:0]                cur_nibble;
    logic                      cur_dp;
    logic [6:0]                seg_low;

    assign slot_end   = (prescaler_reg == PRE_W'(REFRESH_DIV - 1));
    assign frame_wrap = slot_end && (index_reg == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        prescaler_next = slot_end ? '0 : prescaler_reg + 1'b1;
        index_next     = index_reg;
        if (frame_wrap)
            index_next = '0;
        else if (slot_end)
            index_next = index_reg + 1'b1;
    end

    // upper_zero[k]: nibbles k..NUM_DIGITS-1 of the displayed value are all zero
    assign upper_zero[NUM_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_sel[gi]  = (index_reg == IDX_W'(gi));
            assign upper_zero[gi] = upper_zero[gi+1] & (active_value_reg[4*gi +: 4] == 4'h0);
        end
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            assign in_guard = (prescaler_reg < PRE_W'(GUARD_CYCLES));
        end
    endgenerate

    assign blank = blank_lz && !digit_sel[0] && |(digit_sel & upper_zero[NUM_DIGITS-1:0]);

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_sel[k]) begin
                cur_nibble = active_value_reg[4*k +: 4];
                cur_dp     = active_dp_reg[k];
            end
        end
    end

    // Font kept in active-low {g..a} form; polarity applied afterwards
    always_comb begin
        seg_low = 7'h7F;
        case (cur_nibble)
            4'h0: seg_low = 7'b1000000;
            4'h1: seg_low = 7'b1111001;
            4'h2: seg_low = 7'b0100100;
            4'h3: seg_low = 7'b0110000;
            4'h4: seg_low = 7'b0011001;
            4'h5: seg_low = 7'b0010010;
            4'h6: seg_low = 7'b0000010;
            4'h7: seg_low = 7'b1111000;
            4'h8: seg_low = 7'b0000000;
            4'h9: seg_low = 7'b0010000;
            4'hA: seg_low = 7'b0001000;
            4'hB: seg_low = 7'b0000011;
            4'hC: seg_low = 7'b1000110;
            4'hD: seg_low = 7'b0100001;
            4'hE: seg_low = 7'b0000110;
            4'hF: seg_low = 7'b0001110;
            default: seg_low = 7'h7F;
        endcase
    end

    always_comb begin
        seg_next = blank ? SEG_UNLIT : ((SEG_ACTIVE_LOW != 0) ? seg_low : ~seg_low);
        dp_next  = (SEG_ACTIVE_LOW != 0) ? ~cur_dp : cur_dp;
        an_next  = in_guard ? AN_OFF : ((AN_ACTIVE_LOW != 0) ? ~digit_sel : digit_sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_reg     <= '0;
            index_reg         <= '0;
            pending_value_reg <= '0;
            pending_dp_reg    <= '0;
            active_value_reg  <= '0;
            active_dp_reg     <= '0;
            wrapped_reg       <= 1'b0;
            seg_reg           <= SEG_UNLIT;
            dp_reg            <= DP_UNLIT;
            an_reg            <= AN_OFF;
            frame_start_reg   <= 1'b0;
        end else begin
            if (load) begin
                pending_value_reg <= value;
                pending_dp_reg    <= dp_in;
            end
            if (enable) begin
                prescaler_reg <= prescaler_next;
                index_reg     <= index_next;
                // wrapped_reg survives a freeze so the frame pulse fires once on resume
                wrapped_reg   <= frame_wrap;
                if (frame_wrap) begin
                    active_value_reg <= pending_value_reg;
                    active_dp_reg    <= pending_dp_reg;
                end
                seg_reg         <= seg_next;
                dp_reg          <= dp_next;
                an_reg          <= an_next;
                frame_start_reg <= wrapped_reg;
            end else begin
                seg_reg         <= SEG_UNLIT;
                dp_reg          <= DP_UNLIT;
                an_reg          <= AN_OFF;
                frame_start_reg <= 1'b0;
            end
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign an          = an_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_hex7seg_scan_driver.sv
// Bench for hex7seg_scan_driver: time-based display model checked every cycle,
// plus directed scenarios with literal expected segment patterns.
module tb_hex7seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int G     = 1;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;

    logic [6:0]  seg, seg_i;
    logic        dp, dp_i, fs, fs_i;
    logic [3:0]  an, an_i;

    int total = 0;
    int bad   = 0;

    // Active-low {g..a} font for 0..F
    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex7seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(G),
                          .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .enable(enable), .seg(seg), .dp(dp), .an(an),
        .frame_start(fs));

    hex7seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD_CYCLES(G),
                          .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)) dut_inv (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .enable(enable), .seg(seg_i), .dp(dp_i), .an(an_i),
        .frame_start(fs_i));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: t counts enabled cycles since reset; everything follows from it
    int          t = 0;
    int          d, off;
    logic [15:0] pend_v = 16'h0, act_v = 16'h0;
    logic [3:0]  pend_dp = 4'h0, act_dp = 4'h0;
    logic [6:0]  exp_seg = 7'h7F, exp_seg_i = 7'h00;
    logic        exp_dp = 1'b1, exp_dp_i = 1'b0, exp_fs = 1'b0;
    logic [3:0]  exp_an = 4'hF;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            t = 0; pend_v = 16'h0; act_v = 16'h0; pend_dp = 4'h0; act_dp = 4'h0;
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fs = 1'b0;
        end else begin
            if (enable) begin
                d   = (t / DIV) % N;
                off = t % DIV;
                if (blank_lz && d != 0 && ((act_v >> (4 * d)) == 16'h0))
                    exp_seg = 7'h7F;
                else
                    exp_seg = font[act_v[4*d +: 4]];
                exp_dp = ~act_dp[d];
                exp_an = (off < G) ? 4'hF : 4'(~(4'b0001 << d));
                exp_fs = (t > 0) && (t % FRAME == 0);
                t = t + 1;
                if (t % FRAME == 0) begin
                    act_v  = pend_v;
                    act_dp = pend_dp;
                end
            end else begin
                exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF; exp_fs = 1'b0;
            end
            if (load) begin
                pend_v  = value;
                pend_dp = dp_in;
            end
        end
        exp_seg_i = ~exp_seg;
        exp_dp_i  = ~exp_dp;
    end

    initial forever begin
        @(negedge clk);
        chk("an", an, exp_an);
        chk("seg", seg, exp_seg);
        chk("dp", dp, exp_dp);
        chk("frame_start", fs, exp_fs);
        chk("an_inv", an_i, exp_an);
        chk("seg_inv", seg_i, exp_seg_i);
        chk("dp_inv", dp_i, exp_dp_i);
        chk("frame_start_inv", fs_i, exp_fs);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(output int c);
        logic found;
        found = 1'b0;
        c = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            c++;
            if (fs === 1'b1) found = 1'b1;
        end
        if (!found) chk("fs_timeout", fs, 1);
    endtask

    // Called at the negedge showing frame_start; checks each digit's slot
    task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps);
        logic [3:0] an_want;
        logic       dp_want;
        for (int k = 0; k < N; k++) begin
            step(k == 0 ? 1 : DIV);
            an_want = 4'(~(4'b0001 << k));
            dp_want = ~dps[k];
            chk($sformatf("frm_an_d%0d", k), an, an_want);
            chk($sformatf("frm_seg_d%0d", k), seg, segs[7*k +: 7]);
            chk($sformatf("frm_dp_d%0d", k), dp, dp_want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #1 rst = 1'b1;
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_fs", fs, 0);
        chk("rst_seg_inv", seg_i, 7'h00);
        step(2);
        rst = 1'b0;
        step(1);
        chk("c1_an", an, 4'hF);
        step(1);
        chk("c2_an", an, 4'hE);
        chk("c2_seg", seg, 7'h40);
        wait_fs(c);
        chk("first_fs", c, 15);
        wait_fs(c);
        chk("fs_period", c, 16);

        // load mid-frame, shown only from the next frame
        step(5);
        value = 16'h3A9F; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("pre_frame_seg", seg, 7'h40);
        wait_fs(c);
        check_frame({7'h30, 7'h08, 7'h10, 7'h0E}, 4'b0000);

        value = 16'h0050; blank_lz = 1'b1; load = 1'b1;
        step(1);
        load = 1'b0;
        wait_fs(c);
        check_frame({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b0000);
        blank_lz = 1'b0;
        wait_fs(c);
        check_frame({7'h40, 7'h40, 7'h12, 7'h40}, 4'b0000);

        value = 16'h0000; dp_in = 4'b0100; blank_lz = 1'b1; load = 1'b1;
        step(1);
        load = 1'b0;
        wait_fs(c);
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0100);

        // freeze during the digit 2 slot
        wait_fs(c);
        step(9);
        enable = 1'b0;
        step(10);
        chk("dis_an", an, 4'hF);
        chk("dis_seg", seg, 7'h7F);
        enable = 1'b1;
        step(1);
        chk("resume_an", an, 4'b1011);
        wait_fs(c);
        chk("fs_shift", c + 20, 26);

        // asynchronous reset pulse between clock edges
        step(3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        chk("arst_dp", dp, 1);
        chk("arst_fs", fs, 0);
        chk("arst_seg_inv", seg_i, 7'h00);
        step(1);
        rst = 1'b0;
        step(1);
        chk("rr_c1_an", an, 4'hF);
        step(1);
        chk("rr_c2_an", an, 4'hE);
        chk("rr_c2_seg", seg, 7'h40);
        chk("rr_c2_seg_inv", seg_i, 7'h3F);
        value = 16'h0008; load = 1'b1;
        step(1);
        load = 1'b0;
        wait_fs(c);
        step(1);
        chk("eight_an", an, 4'hE);
        chk("eight_seg", seg, 7'h00);
        chk("eight_seg_inv", seg_i, 7'h7F);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
